seq_gen: RTL
============

Name: seq_gen

Overview:
- Serial bit-pattern generator. It is the transmit side of the lab4 serial sequence detector: it drives the `din` stream that a detector such as `seqdetb` consumes.
- A programmable pattern of 1..WIDTH bits is shifted out MSB-first, one bit per `clk`, and repeated a programmable number of times.
- The block replaces hand-written `#delay` stimulus in detector benches and feeds detectors in on-board demos.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LW, $clog2(WIDTH+1), width of the `len` port.
- RW, 4, width of the repeat count.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin transmission; sampled only while `busy`=0.
- stop  input  1  synchronous abort.
- pattern  input  WIDTH  bits to send; bit[len-1] goes first, bit[0] goes last.
- len  input  LW  number of bits per repetition.
- reps  input  RW  number of repetitions.
- dout  output  1  serial data, connects to detector `din`.
- dvalid  output  1  high while `dout` carries a pattern bit.
- busy  output  1  high while transmitting.
- done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `clr` is asynchronous and active-high.
- Reset values: `clr`=1 immediately forces `dout`=0, `dvalid`=0, `busy`=0, `done`=0, state IDLE. All outputs are registered.
- States: IDLE, SHIFT, DONE.
- Timing convention: "cycle k" means the interval after rising edge Ek.
- IDLE:
  - `start`=1 at edge E0 captures `pattern`, `len` and `reps`, then moves to SHIFT.
  - Length clamping: `len`=0 or `len`>WIDTH is treated as WIDTH.
  - Repeat clamping: `reps`=0 is treated as 1, unless the optional feature is compiled in.
- SHIFT:
  - Cycle k (1 ≤ k ≤ L) drives `dout`=pattern[L-k], with `dvalid`=1 and `busy`=1.
  - Latency: first bit appears in cycle 1, i.e. one clock after `start` is sampled.
  - After bit 0, if repetitions remain, the bit index reloads to L-1 with no gap cycle, so the stream continues back-to-back.
- DONE:
  - After the final bit, state becomes DONE for exactly one cycle with `done`=1, `dvalid`=0, `dout`=0, `busy`=0.
  - Next state is IDLE, unless `start`=1 is sampled in the DONE cycle; that starts a new transfer exactly as from IDLE.
- Input changes: `start` while `busy`=1 is ignored. Changes to `pattern`, `len` or `reps` while `busy`=1 have no effect because the values were captured at start.
- stop:
  - `stop`=1 sampled in SHIFT or DONE returns the block to IDLE at that edge, with `dout`=0, `dvalid`=0, `busy`=0 and no `done` pulse.
  - `stop` and `start` together in IDLE or DONE: `stop` wins and `start` is ignored.
- Reset mid-operation: `clr` mid-transfer aborts asynchronously to the reset values. No `done` pulse is produced.
- Width rules:
  - Bit index is LW bits and decrements.
  - Repeat counter is RW bits and decrements once at each repetition boundary.
  - No wrap is possible because values are clamped at capture.

Optional Feature:
- Macro SEQ_GEN_LOOP_EN.
- Defined: `reps`=0 means loop forever. The pattern repeats back-to-back until `stop` or `clr`, and `done` never pulses for that transfer.
- Not defined: `reps`=0 is treated as 1. Port list is identical in both builds.

Decomposition:
- Shared package seq_gen_pkg:
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH and RW constants.
  - A clamp function for `len`.
- Single module. No sub-module is warranted; the shift/index logic is one always block plus the next-state logic.

Test Plan:
- WIDTH=8, pattern=8'h0D, len=4, reps=1, `start` at E0: `dout`=1,1,0,1 in cycles 1-4 with `dvalid`=`busy`=1; `done`=1 only in cycle 5; IDLE in cycle 6.
- Same pattern, reps=3: 12 consecutive `dvalid` cycles carrying 1101 1101 1101; `done` in cycle 13. With `seqdetb` attached, `dout` asserts 3 times (overlap rules per detector).
- len=0 with pattern=8'hA5: 8 bits 1,0,1,0,0,1,0,1 sent, then `done`. `start` pulsed in cycle 3 is ignored.
- `stop` asserted in cycle 2 of an 8-bit transfer: at the next edge `dvalid`=0, `busy`=0, and `done` never pulses. `start`+`stop` together in IDLE leaves the block idle.
- `clr` raised mid-transfer between clock edges: outputs go to 0 immediately. After release, a new `start` transmits correctly from bit[len-1].
- SEQ_GEN_LOOP_EN build, reps=0, pattern 1101: the stream repeats at least 10 times with no `done`; `stop` ends it cleanly. Non-macro build with the same stimulus sends once and pulses `done`.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding, default sizes and length clamp for seq_gen
package seq_gen_pkg;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  localparam int WIDTH_DEF = 8;
  localparam int RW_DEF = 4;
  function automatic int clamp_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction
endpackage

// File: rtl/seq_gen.sv
// seq_gen: MSB-first serial pattern generator with repeat count; SEQ_GEN_LOOP_EN makes reps=0 loop forever
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LW = $clog2(WIDTH + 1),
  parameter int RW = RW_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [RW-1:0]    reps,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d, sh;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, cap_len;
  logic [RW-1:0] rep_q, rep_d, cap_rep;
  logic loop_q, loop_d, cap_loop, dout_q, dout_d, busy_q, busy_d, done_q, done_d;
  assign cap_len = LW'(clamp_len(int'(len), WIDTH));
  assign cap_rep = reps == '0 ? RW'(1) : reps;
`ifdef SEQ_GEN_LOOP_EN
  assign cap_loop = reps == '0;
`else
  assign cap_loop = 1'b0;
`endif
  always_comb begin
    state_d = IDLE;
    pat_d = pat_q;
    len_d = len_q;
    idx_d = idx_q;
    rep_d = rep_q;
    loop_d = loop_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (start && !stop && state_q != SHIFT) begin
      state_d = SHIFT;
      pat_d = pattern;
      len_d = cap_len;
      idx_d = cap_len - LW'(1);
      rep_d = cap_rep;
      loop_d = cap_loop;
      busy_d = 1'b1;
    end else if (state_q == SHIFT && !stop) begin
      state_d = SHIFT;
      busy_d = 1'b1;
      if (idx_q != '0) idx_d = idx_q - LW'(1);
      else if (loop_q || rep_q > RW'(1)) begin
        // reload with no gap so repetitions run back-to-back
        idx_d = len_q - LW'(1);
        rep_d = loop_q ? rep_q : rep_q - RW'(1);
      end else begin
        state_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
    sh = pat_d >> idx_d;
    dout_d = busy_d & sh[0];
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      rep_q <= '0;
      loop_q <= 1'b0;
      dout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      idx_q <= idx_d;
      rep_q <= rep_d;
      loop_q <= loop_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign dout = dout_q;
  assign dvalid = busy_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
